// File: rtl/zeroheti_apb_to_obi.sv
// APB completer to OBI manager bridge.
// Each APB transfer is replayed as exactly one OBI transaction, and at most one OBI
// transaction is outstanding at any time. All outputs come from registers, so there is
// no combinational path from APB inputs to OBI outputs or from OBI inputs to APB outputs.
//
// Build option: define ZEROHETI_APB2OBI_ERR_EN to return the OBI err response as pslverr.
// When it is undefined, pslverr is tied to 0 and err is ignored. Handshake timing is the
// same in both builds.
//
// Only DataWidth = 32 is supported.

module zeroheti_apb_to_obi #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  // APB completer side
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [AddrWidth-1:0]   paddr,
  input  logic [DataWidth-1:0]   pwdata,
  input  logic [DataWidth/8-1:0] pstrb,
  output logic                   pready,
  output logic [DataWidth-1:0]   prdata,
  output logic                   pslverr,

  // OBI manager side
  output logic                   obi_req,
  input  logic                   obi_gnt,
  output logic [AddrWidth-1:0]   obi_addr,
  output logic                   obi_we,
  output logic [DataWidth/8-1:0] obi_be,
  output logic [DataWidth-1:0]   obi_wdata,
  output logic [IdWidth-1:0]     obi_aid,
  output logic                   obi_rready,
  input  logic                   obi_rvalid,
  input  logic [DataWidth-1:0]   obi_rdata,
  input  logic                   obi_err
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BeWidth-1:0]    be_q, be_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [DataWidth-1:0]  prdata_q, prdata_d;

`ifdef ZEROHETI_APB2OBI_ERR_EN
  logic                  err_q, err_d;
`else
  // err has no effect in this build; the name keeps the lint tool quiet about it.
  logic                  unused_err;
  assign unused_err = obi_err;
`endif

  // Next-state and request/response capture logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
`ifdef ZEROHETI_APB2OBI_ERR_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Setup-only cycles (psel && !penable) are ignored; we latch on the access phase.
        if (psel && penable) begin
          addr_d  = paddr;
          we_d    = pwrite;
          wdata_d = pwdata;
          be_d    = pwrite ? pstrb : {BeWidth{1'b1}};
          state_d = StReq;
        end
      end

      StReq: begin
        // req stays up with stable fields until granted.
        if (obi_gnt) begin
          state_d = StResp;
        end
      end

      StResp: begin
        if (obi_rvalid) begin
          prdata_d = we_q ? '0 : obi_rdata;
`ifdef ZEROHETI_APB2OBI_ERR_EN
          err_d    = obi_err;
`endif
          state_d  = StDone;
        end
      end

      StDone: begin
        // One-cycle pready pulse; psel is not consulted, so a requester that dropped
        // psel early still gets the pulse and the bridge recovers to idle.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef ZEROHETI_APB2OBI_ERR_EN
  // Error flag captured with the response; held until the next response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pslverr = err_q;
`else
  assign pslverr = 1'b0;
`endif

  // req is also masked by reset so it drops in the same cycle reset is asserted.
  assign obi_req    = rst_ni && (state_q == StReq);
  assign obi_addr   = addr_q;
  assign obi_we     = we_q;
  assign obi_be     = be_q;
  assign obi_wdata  = wdata_q;
  assign obi_aid    = '0;
  assign obi_rready = 1'b1;

  assign pready     = (state_q == StDone);
  assign prdata     = prdata_q;

endmodule
